// File: rtl/serpent_encrypt_arbiter.sv
// Round-robin front end that shares one serpent_encrypt_top core among N_REQ requesters.
// Define SERPENT_ARB_TIMEOUT_EN to build the BUSY watchdog that aborts a stalled job.
module serpent_encrypt_arbiter #(
    parameter int  N_REQ          = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int ID_W           = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*256-1:0]   i_req_key,
    input  logic [N_REQ*128-1:0]   i_req_data,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [127:0]           o_rsp_data,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic                   o_core_master_key_valid,
    output logic                   o_core_enable_encrypt,
    output logic [255:0]           o_core_key,
    output logic [127:0]           o_core_data,
    input  logic [127:0]           i_core_data,
    input  logic                   i_core_data_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [ID_W:0]   N_REQ_C = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [255:0]     key_q, key_d;
    logic [127:0]     data_q, data_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [127:0]     rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;

`ifdef SERPENT_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    grant_off;
    logic [ID_W:0]      grant_sum;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;

    // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        req_dbl     = {i_req_valid, i_req_valid} >> rr_ptr_q;
        req_rot     = req_dbl[N_REQ-1:0];
        grant_found = |req_rot;
        grant_off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) grant_off = ID_W'(i);
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        if (grant_sum >= N_REQ_C) grant_sum = grant_sum - N_REQ_C;
        grant_idx = grant_sum[ID_W-1:0];
    end

    // Ready is masked by reset so every output reads 0 while i_rstn is low.
    always_comb begin
        o_req_ready = '0;
        if (i_rstn && state_q == ST_IDLE && grant_found) o_req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        key_d       = key_q;
        data_d      = data_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
`ifdef SERPENT_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    key_d    = i_req_key[32'(grant_idx)*256 +: 256];
                    data_d   = i_req_data[32'(grant_idx)*128 +: 128];
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
                    state_d  = ST_BUSY;
`ifdef SERPENT_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (i_core_data_valid) begin
                    rsp_data_d  = i_core_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`ifdef SERPENT_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            key_q       <= '0;
            data_q      <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SERPENT_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            key_q       <= key_d;
            data_q      <= data_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef SERPENT_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

`ifdef SERPENT_ARB_TIMEOUT_EN
    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    // Core controls fall as soon as BUSY is left, so the core sees a restart gap between jobs.
    assign o_core_master_key_valid = (state_q == ST_BUSY);
    assign o_core_enable_encrypt   = (state_q == ST_BUSY);
    assign o_core_key              = key_q;
    assign o_core_data             = data_q;
    assign o_rsp_valid             = rsp_valid_q;
    assign o_rsp_data              = rsp_data_q;
    assign o_rsp_id                = id_q;
    assign o_busy                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serpent_encrypt_arbiter.sv
// Self-checking bench for serpent_encrypt_arbiter with a behavioural core stub and round-robin model.
// Define SERPENT_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 16).
module tb_serpent_encrypt_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = $clog2(N_REQ);

    logic                 i_clk;
    logic                 i_rstn;
    logic [N_REQ-1:0]     reqValid;
    logic [N_REQ-1:0]     o_req_ready;
    logic [N_REQ*256-1:0] i_req_key;
    logic [N_REQ*128-1:0] i_req_data;
    logic                 o_rsp_valid;
    logic                 i_rsp_ready;
    logic [127:0]         o_rsp_data;
    logic [ID_W-1:0]      o_rsp_id;
    logic                 o_rsp_err;
    logic                 o_busy;
    logic                 o_core_master_key_valid;
    logic                 o_core_enable_encrypt;
    logic [255:0]         o_core_key;
    logic [127:0]         o_core_data;
    logic [127:0]         i_core_data;
    logic                 i_core_data_valid;

    logic [255:0] keys  [N_REQ];
    logic [127:0] datas [N_REQ];

    int total = 0;
    int bad   = 0;
    int mPtr  = 0;
    int stubLat = 0;
    int stubCnt = 0;
    bit stubNever = 0;
    bit stubNoise = 1;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign i_req_key[g*256 +: 256]  = keys[g];
        assign i_req_data[g*128 +: 128] = datas[g];
    end

    serpent_encrypt_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYCLES(16)) dut (
        .i_clk                   (i_clk),
        .i_rstn                  (i_rstn),
        .i_req_valid             (reqValid),
        .o_req_ready             (o_req_ready),
        .i_req_key               (i_req_key),
        .i_req_data              (i_req_data),
        .o_rsp_valid             (o_rsp_valid),
        .i_rsp_ready             (i_rsp_ready),
        .o_rsp_data              (o_rsp_data),
        .o_rsp_id                (o_rsp_id),
        .o_rsp_err               (o_rsp_err),
        .o_busy                  (o_busy),
        .o_core_master_key_valid (o_core_master_key_valid),
        .o_core_enable_encrypt   (o_core_enable_encrypt),
        .o_core_key              (o_core_key),
        .o_core_data             (o_core_data),
        .i_core_data             (i_core_data),
        .i_core_data_valid       (i_core_data_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Stand-in for the real cipher: any fixed keyed mixing is enough to prove the right key/data reached the core.
    function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] d);
        return d ^ k[127:0] ^ {k[250:128], k[255:251]} ^ 128'h5a5a_c3c3_0ff0_1234_8765_a5a5_3c3c_f00f;
    endfunction

    function automatic logic [255:0] randKey();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round robin as stated: first valid requester at or after the pointer, wrapping around.
    function automatic int modelGrant(input logic [N_REQ-1:0] mask, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (mask[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    // Core stub: answers stubLat cycles into an enable window, and optionally spits noise while disabled.
    always @(negedge i_clk) begin
        if (o_core_enable_encrypt === 1'b1) begin
            if (!stubNever && stubCnt == stubLat) begin
                i_core_data_valid = 1'b1;
                i_core_data       = cipher(o_core_key, o_core_data);
            end else begin
                i_core_data_valid = 1'b0;
                i_core_data       = randData();
            end
            stubCnt++;
        end else begin
            stubCnt           = 0;
            i_core_data_valid = stubNoise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_core_data       = randData();
        end
    end

    // Entered at posedge+1 in IDLE with the request already presented; leaves at posedge+1 back in IDLE.
    task automatic serveJob(input int expId, input int lat, input int hold, input string tag);
        logic [255:0]     k;
        logic [127:0]     d;
        logic [127:0]     expCt;
        logic [N_REQ-1:0] expReady;
        int cycles;
        bit stableBad;
        bit holdBad;
        k        = keys[expId];
        d        = datas[expId];
        expCt    = cipher(k, d);
        stubLat  = lat;
        expReady = '0;
        expReady[expId] = 1'b1;
        #1;
        total++;
        if (o_req_ready !== expReady) begin
            bad++;
            $display("[TB] FAIL %s grant: ready=%b expected=%b", tag, o_req_ready, expReady);
        end
        @(posedge i_clk); #1;
        reqValid[expId] = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_core_enable_encrypt !== 1'b1 || o_core_master_key_valid !== 1'b1 ||
            o_core_key !== k || o_core_data !== d || o_req_ready !== '0) begin
            bad++;
            $display("[TB] FAIL %s busy_entry: busy=%b en=%b kv=%b data=%h ready=%b expected busy=1 en=1 kv=1 data=%h ready=0",
                     tag, o_busy, o_core_enable_encrypt, o_core_master_key_valid, o_core_data, o_req_ready, d);
        end
        cycles    = 0;
        stableBad = 0;
        while (o_rsp_valid !== 1'b1 && cycles < 100) begin
            if (o_core_key !== k || o_core_data !== d || o_core_enable_encrypt !== 1'b1 || o_req_ready !== '0)
                stableBad = 1;
            @(posedge i_clk); #1;
            cycles++;
        end
        total++;
        if (o_rsp_valid !== 1'b1 || cycles != lat + 1) begin
            bad++;
            $display("[TB] FAIL %s latency: rsp_valid=%b after %0d cycles, expected 1 after %0d", tag, o_rsp_valid, cycles, lat + 1);
        end
        total++;
        if (stableBad) begin
            bad++;
            $display("[TB] FAIL %s busy_stable: core key/data/controls changed during BUSY, expected stable", tag);
        end
        total++;
        if (o_rsp_id !== ID_W'(expId) || o_rsp_data !== expCt || o_rsp_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s response: id=%0d data=%h err=%b expected id=%0d data=%h err=0",
                     tag, o_rsp_id, o_rsp_data, o_rsp_err, expId, expCt);
        end
        total++;
        if (o_core_enable_encrypt !== 1'b0 || o_core_master_key_valid !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s resp_ctrl: en=%b kv=%b busy=%b expected en=0 kv=0 busy=1",
                     tag, o_core_enable_encrypt, o_core_master_key_valid, o_busy);
        end
        holdBad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk); #1;
            if (o_rsp_valid !== 1'b1 || o_rsp_data !== expCt || o_rsp_id !== ID_W'(expId) ||
                o_core_enable_encrypt !== 1'b0 || o_req_ready !== '0 || o_busy !== 1'b1)
                holdBad = 1;
        end
        if (hold > 0) begin
            total++;
            if (holdBad) begin
                bad++;
                $display("[TB] FAIL %s backpressure: response/controls/ready moved while held, expected stable data=%h", tag, expCt);
            end
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        total++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s release: rsp_valid=%b busy=%b expected 0 0", tag, o_rsp_valid, o_busy);
        end
        mPtr = (expId + 1) % N_REQ;
    endtask

    task automatic test_reset();
        i_rstn      = 1'b0;
        i_rsp_ready = 1'b0;
        reqValid    = '1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        total++;
        if (o_busy !== 1'b0 || o_core_enable_encrypt !== 1'b0 || o_core_master_key_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: busy=%b en=%b kv=%b expected 0", o_busy, o_core_enable_encrypt, o_core_master_key_valid);
        end
        total++;
        if (o_rsp_valid !== 1'b0 || o_rsp_data !== '0 || o_rsp_id !== '0 || o_rsp_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rsp: valid=%b data=%h id=%0d err=%b expected all 0", o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_err);
        end
        total++;
        if (o_core_key !== '0 || o_core_data !== '0) begin
            bad++;
            $display("[TB] FAIL reset_core_bus: key=%h data=%h expected 0", o_core_key, o_core_data);
        end
        total++;
        if (o_req_ready !== '0) begin
            bad++;
            $display("[TB] FAIL reset_ready: ready=%b expected 0", o_req_ready);
        end
        reqValid = '0;
        #2 i_rstn = 1'b1;
        mPtr = 0;
        @(posedge i_clk); #1;
        total++;
        if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: busy=%b rsp_valid=%b expected 0 0", o_busy, o_rsp_valid);
        end
    endtask

    task automatic test_single();
        keys[0]     = 256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100;
        datas[0]    = 128'h0123456789abcdeffedcba9876543210;
        reqValid    = '0;
        reqValid[0] = 1'b1;
        serveJob(modelGrant(reqValid, mPtr), 3, 2, "single");
    endtask

    task automatic test_back_to_back();
        int order [5] = '{0, 1, 2, 3, 0};
        reqValid = '0;
        i_rstn   = 1'b0;
        @(posedge i_clk); #3;
        i_rstn = 1'b1;
        mPtr   = 0;
        @(posedge i_clk); #1;
        for (int k = 0; k < N_REQ; k++) begin
            keys[k]  = randKey();
            datas[k] = randData() ^ 128'(k);
        end
        reqValid = '1;
        for (int j = 0; j < 5; j++) begin
            serveJob(order[j], int'($urandom_range(0, 4)), 0, "back_to_back");
            keys[order[j]]     = randKey();
            datas[order[j]]    = randData();
            reqValid[order[j]] = 1'b1;
        end
        reqValid = '0;
    endtask

    task automatic test_round_robin();
        int g;
        for (int j = 0; j < 20; j++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!reqValid[k] && $urandom_range(0, 1) == 1) begin
                    keys[k]     = randKey();
                    datas[k]    = randData();
                    reqValid[k] = 1'b1;
                end
            end
            if (reqValid == '0) begin
                g           = int'($urandom_range(0, N_REQ - 1));
                keys[g]     = randKey();
                datas[g]    = randData();
                reqValid[g] = 1'b1;
            end
            g = modelGrant(reqValid, mPtr);
            serveJob(g, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), "round_robin");
        end
        while (reqValid != '0) begin
            g = modelGrant(reqValid, mPtr);
            serveJob(g, int'($urandom_range(0, 3)), 0, "round_robin_drain");
        end
    endtask

    task automatic test_backpressure();
        int g;
        reqValid = '0;
        for (int k = 0; k < N_REQ; k += 3) begin
            keys[k]     = randKey();
            datas[k]    = randData();
            reqValid[k] = 1'b1;
        end
        g = modelGrant(reqValid, mPtr);
        serveJob(g, 2, 10, "backpressure");
        g = modelGrant(reqValid, mPtr);
        serveJob(g, 1, 0, "backpressure_next");
    endtask

    task automatic test_reset_mid_busy();
        reqValid    = '0;
        keys[1]     = randKey();
        datas[1]    = randData();
        reqValid[1] = 1'b1;
        stubLat     = 40;
        @(posedge i_clk); #1;
        reqValid = '0;
        total++;
        if (o_busy !== 1'b1 || o_core_enable_encrypt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_busy: busy=%b en=%b expected 1 1", o_busy, o_core_enable_encrypt);
        end
        repeat (3) @(posedge i_clk);
        #3;
        keys[2]     = randKey();
        datas[2]    = randData();
        reqValid[2] = 1'b1;
        i_rstn      = 1'b0;
        #1;
        total++;
        if (o_busy !== 1'b0 || o_core_enable_encrypt !== 1'b0 || o_core_master_key_valid !== 1'b0 ||
            o_core_key !== '0 || o_core_data !== '0 || o_req_ready !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_ctrl: busy=%b en=%b kv=%b ready=%b key=%h expected all 0",
                     o_busy, o_core_enable_encrypt, o_core_master_key_valid, o_req_ready, o_core_key);
        end
        total++;
        if (o_rsp_valid !== 1'b0 || o_rsp_data !== '0 || o_rsp_id !== '0 || o_rsp_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_rsp: valid=%b data=%h id=%0d err=%b expected all 0", o_rsp_valid, o_rsp_data, o_rsp_id, o_rsp_err);
        end
        repeat (2) @(posedge i_clk);
        reqValid = '0;
        #3 i_rstn = 1'b1;
        mPtr = 0;
        @(posedge i_clk); #1;
        total++;
        if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_dropped: rsp_valid=%b busy=%b expected 0 0", o_rsp_valid, o_busy);
        end
        reqValid[2] = 1'b1;
        serveJob(modelGrant(reqValid, mPtr), 2, 1, "after_reset");
    endtask

`ifdef SERPENT_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        int cycles;
        reqValid    = '0;
        keys[3]     = randKey();
        datas[3]    = randData();
        reqValid[3] = 1'b1;
        stubNever   = 1;
        @(posedge i_clk); #1;
        reqValid = '0;
        cycles   = 0;
        while (o_rsp_valid !== 1'b1 && cycles < 100) begin
            @(posedge i_clk); #1;
            cycles++;
        end
        total++;
        if (o_rsp_valid !== 1'b1 || cycles != 16) begin
            bad++;
            $display("[TB] FAIL watchdog_time: rsp_valid=%b after %0d cycles, expected 1 after 16", o_rsp_valid, cycles);
        end
        total++;
        if (o_rsp_err !== 1'b1 || o_rsp_data !== '0 || o_rsp_id !== ID_W'(3) || o_core_enable_encrypt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL watchdog_rsp: err=%b data=%h id=%0d en=%b expected err=1 data=0 id=3 en=0",
                     o_rsp_err, o_rsp_data, o_rsp_id, o_core_enable_encrypt);
        end
        stubNever   = 0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        mPtr        = 0;
        keys[0]     = randKey();
        datas[0]    = randData();
        reqValid[0] = 1'b1;
        serveJob(modelGrant(reqValid, mPtr), 3, 0, "after_watchdog");
    endtask
`endif

    initial begin
        i_rstn      = 1'b0;
        i_rsp_ready = 1'b0;
        reqValid    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            keys[k]  = '0;
            datas[k] = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_backpressure();
        test_reset_mid_busy();
`ifdef SERPENT_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
